// File: rtl/shift_xfer_arbiter_pkg.sv
// Shared types and constants for the shift-register transfer arbiter.
package shift_xfer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/shift_xfer_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer moves only when a grant is taken.
module shift_xfer_arbiter_rr_arb2 (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic prio_b;

  // A grant is always an acceptance, since it is only raised for an active request.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && (!req_b || !prio_b)) gnt_a = 1'b1;
      else if (req_b)                   gnt_b = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST)       prio_b <= 1'b0;
    else if (gnt_a) prio_b <= 1'b1;
    else if (gnt_b) prio_b <= 1'b0;
  end

endmodule

// File: rtl/shift_xfer_arbiter.sv
// Arbitrates two requesters onto a serial shift register, loads a word and returns the bits it displaced.
//   state    | meaning
//   ST_IDLE  | waiting for a request; arbiter enabled
//   ST_SHIFT | WIDTH shift cycles, driving SR_SI and capturing SR_SO
//   ST_FIN   | one-cycle DONE with captured word on RD_DATA
module shift_xfer_arbiter
  import shift_xfer_arbiter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic             A_DIR,
  input  logic             B_VALID,
  output logic             B_READY,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic             B_DIR,
  output logic             SR_SHIFT,
  output logic             SR_SI,
  output logic             SR_LR,
  input  logic             SR_SO,
  output logic             BUSY,
  output logic             DONE,
  output logic             DONE_ID,
  output logic [WIDTH-1:0] RD_DATA
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] data_q, cap_q, cap_nxt, rd_q;
  logic             dir_q, id_q;
  logic             gnt_a, gnt_b, accept;

  shift_xfer_arbiter_rr_arb2 u_rr_arb2 (
    .CLK   (CLK),
    .RST   (RST),
    .en    ((state == ST_IDLE) && RST),
    .req_a (A_VALID),
    .req_b (B_VALID),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign accept  = gnt_a | gnt_b;
  assign A_READY = gnt_a;
  assign B_READY = gnt_b;

  always_ff @(posedge CLK) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    SR_SHIFT = 1'b0;
    SR_SI    = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    DONE_ID  = ID_A;
    case (state)
      ST_SHIFT: begin
        SR_SHIFT = 1'b1;
        SR_SI    = (dir_q == DIR_LEFT) ? data_q[LAST - cnt] : data_q[cnt];
        BUSY     = 1'b1;
      end
      ST_FIN: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        DONE_ID = id_q;
      end
      default: ;
    endcase
  end

  // Direction register doubles as SR_LR so the datapath's SO stays stable between transfers.
  assign SR_LR   = dir_q;
  assign RD_DATA = rd_q;
  assign cap_nxt = (dir_q == DIR_LEFT) ? {cap_q[WIDTH-2:0], SR_SO} : {SR_SO, cap_q[WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt    <= '0;
      data_q <= '0;
      dir_q  <= DIR_LEFT;
      id_q   <= ID_A;
      cap_q  <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      cnt    <= '0;
      data_q <= gnt_b ? B_DATA : A_DATA;
      dir_q  <= gnt_b ? B_DIR : A_DIR;
      id_q   <= gnt_b ? ID_B : ID_A;
    end else if (state == ST_SHIFT) begin
      cap_q <= cap_nxt;
      if (cnt == LAST) begin
        cnt  <= '0;
        rd_q <= cap_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
